pong_match_ctrl: RTL

Match sequencer for the Pong top level. Runs on the pixel clock and advances only on game-tick pulses. Owns the paddle positions, the ball speed, the serve direction and the scores. Holds the collision controller's `reset` asserted whenever the ball must be parked, and releases it during live play. Detects goals from the ball position reported by the collision controller.

---
 rtl/pong_match_ctrl_pkg.sv | 38 +++
 rtl/pong_match_ctrl_paddle_mover.sv | 53 +++++
 rtl/pong_match_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// Shared types, widths and playfield defaults for the Pong match sequencer.
// Also holds the saturating velocity step used by the speed-up logic.
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned VEL_W   = 4;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned Y_CEIL_DEF        = 5;
    localparam int unsigned Y_FLOOR_DEF       = 475;
    localparam int unsigned X_LWALL_DEF       = 5;
    localparam int unsigned X_RWALL_DEF       = 635;
    localparam int unsigned BALL_W_DEF        = 10;
    localparam int unsigned PADDLE_H_DEF      = 100;
    localparam int unsigned PADDLE_STEP_DEF   = 4;
    localparam int unsigned PADDLE_Y_INIT_DEF = 190;

    function automatic logic [VEL_W-1:0] vel_step(input logic [VEL_W-1:0] v,
                                                  input logic [VEL_W-1:0] vmax);
        logic [VEL_W-1:0] r;
        if (v >= vmax) begin
            r = vmax;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_paddle_mover.sv
// One paddle: steps up/down on enabled ticks with saturation at both limits,
// and snaps back to the centre position when recentre is asserted.
module paddle_mover
    import pong_match_ctrl_pkg::*;
#(
    parameter int unsigned STEP = PADDLE_STEP_DEF,
    parameter int unsigned MIN  = Y_CEIL_DEF,
    parameter int unsigned MAX  = Y_FLOOR_DEF - PADDLE_H_DEF,
    parameter int unsigned INIT = PADDLE_Y_INIT_DEF
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               up_i,
    input  logic               down_i,
    input  logic               recentre_i,
    output logic [COORD_W-1:0] y_o
);

    localparam logic [COORD_W-1:0] STEP_C = 10'(STEP);
    localparam logic [COORD_W-1:0] MIN_C  = 10'(MIN);
    localparam logic [COORD_W-1:0] MAX_C  = 10'(MAX);
    localparam logic [COORD_W-1:0] INIT_C = 10'(INIT);

    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] y_d;

    // Next paddle position: recentre wins, opposing buttons cancel out.
    always_comb begin
        y_d = y_q;
        if (recentre_i) begin
            y_d = INIT_C;
        end else if (enable_i && up_i && !down_i) begin
            y_d = (y_q < MIN_C + STEP_C) ? MIN_C : (y_q - STEP_C);
        end else if (enable_i && down_i && !up_i) begin
            y_d = (y_q > MAX_C - STEP_C) ? MAX_C : (y_q + STEP_C);
        end else begin
            y_d = y_q;
        end
    end

    // Paddle position register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            y_q <= INIT_C;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/over flow, tick counter, scores,
// ball speed and paddle control, all advanced by game_tick pulses.
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int unsigned Y_CEIL        = Y_CEIL_DEF,
    parameter int unsigned Y_FLOOR       = Y_FLOOR_DEF,
    parameter int unsigned X_LWALL       = X_LWALL_DEF,
    parameter int unsigned X_RWALL       = X_RWALL_DEF,
    parameter int unsigned BALL_W        = BALL_W_DEF,
    parameter int unsigned PADDLE_H      = PADDLE_H_DEF,
    parameter int unsigned PADDLE_STEP   = PADDLE_STEP_DEF,
    parameter int unsigned PADDLE_Y_INIT = PADDLE_Y_INIT_DEF,
    parameter int unsigned WIN_SCORE     = 7,
    parameter int unsigned SERVE_TICKS   = 30,
    parameter int unsigned POINT_TICKS   = 60,
    parameter int unsigned SPEEDUP_TICKS = 120,
    parameter int unsigned BASE_VEL      = 2,
    parameter int unsigned MAX_VEL       = 8
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               game_tick,
    input  logic               btn_start,
    input  logic               btn_a_up,
    input  logic               btn_a_dn,
    input  logic               btn_b_up,
    input  logic               btn_b_dn,
    input  logic [COORD_W-1:0] x_ball,
    output logic [COORD_W-1:0] y_paddleA,
    output logic [COORD_W-1:0] y_paddleB,
    output logic               ball_reset,
    output logic [VEL_W-1:0]   x_ball_vel,
    output logic [VEL_W-1:0]   y_ball_vel,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               game_over,
    output logic               winner
);

    localparam logic [COORD_W-1:0] X_LWALL_C = 10'(X_LWALL);
    localparam logic [COORD_W:0]   X_RWALL_C = 11'(X_RWALL);
    localparam logic [COORD_W:0]   BALL_W_C  = 11'(BALL_W);
    localparam logic [CNT_W-1:0]   SERVE_C   = 8'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   POINT_C   = 8'(POINT_TICKS);
    localparam logic [CNT_W-1:0]   SPEEDUP_C = 8'(SPEEDUP_TICKS);
    localparam logic [VEL_W-1:0]   BASE_C    = 4'(BASE_VEL);
    localparam logic [VEL_W-1:0]   MAX_C     = 4'(MAX_VEL);
    localparam logic [SCORE_W-1:0] WIN_C     = 4'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_s;
    logic [VEL_W-1:0]   vel_q, vel_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               ball_reset_q, ball_reset_d;
    logic               game_over_q, game_over_d;
    logic               btn_start_q;
    logic               start_rise_s;
    logic               goal_l_s, goal_r_s;
    logic [COORD_W:0]   x_right_s;
    logic               paddle_en_s;
    logic               recentre_s;

    assign start_rise_s = btn_start & ~btn_start_q;
    assign cnt_inc_s    = cnt_q + 8'd1;
    assign x_right_s    = {1'b0, x_ball} + BALL_W_C;
    assign goal_l_s     = (x_ball <= X_LWALL_C);
    assign goal_r_s     = (x_right_s >= X_RWALL_C);

    // State, tick counter and start-button history.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            btn_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_start_q <= btn_start;
        end
    end

    // Next state plus counter, score, speed and serve-direction updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vel_d       = vel_q;
        score_a_d   = score_a_q;
        score_b_d   = score_b_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        recentre_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                score_a_d   = 4'd0;
                score_b_d   = 4'd0;
                serve_dir_d = 1'b0;
                if (start_rise_s) begin
                    state_d = ST_SERVE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (game_tick) begin
                    if (cnt_inc_s == SERVE_C) begin
                        state_d = ST_PLAY;
                        vel_d   = BASE_C;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PLAY: begin
                if (game_tick) begin
                    // The left goal line is tested first when both could fire.
                    if (goal_l_s) begin
                        score_b_d   = score_b_q + 4'd1;
                        serve_dir_d = 1'b1;
                        state_d     = ST_POINT;
                        cnt_d       = 8'd0;
                    end else if (goal_r_s) begin
                        score_a_d   = score_a_q + 4'd1;
                        serve_dir_d = 1'b0;
                        state_d     = ST_POINT;
                        cnt_d       = 8'd0;
                    end else if (cnt_inc_s == SPEEDUP_C) begin
                        vel_d = vel_step(vel_q, MAX_C);
                        cnt_d = 8'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_POINT: begin
                if ((score_a_q == WIN_C) || (score_b_q == WIN_C)) begin
                    state_d  = ST_OVER;
                    winner_d = (score_b_q == WIN_C);
                    cnt_d    = 8'd0;
                end else if (game_tick) begin
                    if (cnt_inc_s == POINT_C) begin
                        state_d    = ST_SERVE;
                        recentre_s = 1'b1;
                        cnt_d      = 8'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_OVER: begin
                if (start_rise_s) begin
                    score_a_d   = 4'd0;
                    score_b_d   = 4'd0;
                    serve_dir_d = 1'b0;
                    state_d     = ST_SERVE;
                    recentre_s  = 1'b1;
                    cnt_d       = 8'd0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags change with the state.
    always_comb begin
        ball_reset_d = (state_d != ST_PLAY);
        game_over_d  = (state_d == ST_OVER);
        paddle_en_s  = game_tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
    end

    // Match datapath registers.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vel_q       <= 4'd0;
            score_a_q   <= 4'd0;
            score_b_q   <= 4'd0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            vel_q       <= vel_d;
            score_a_q   <= score_a_d;
            score_b_q   <= score_b_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
        end
    end

    // Registered status flags.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
        end
    end

    paddle_mover #(
        .STEP (PADDLE_STEP),
        .MIN  (Y_CEIL),
        .MAX  (Y_FLOOR - PADDLE_H),
        .INIT (PADDLE_Y_INIT)
    ) u_paddle_a (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .enable_i   (paddle_en_s),
        .up_i       (btn_a_up),
        .down_i     (btn_a_dn),
        .recentre_i (recentre_s),
        .y_o        (y_paddleA)
    );

    paddle_mover #(
        .STEP (PADDLE_STEP),
        .MIN  (Y_CEIL),
        .MAX  (Y_FLOOR - PADDLE_H),
        .INIT (PADDLE_Y_INIT)
    ) u_paddle_b (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .enable_i   (paddle_en_s),
        .up_i       (btn_b_up),
        .down_i     (btn_b_dn),
        .recentre_i (recentre_s),
        .y_o        (y_paddleB)
    );

    assign ball_reset = ball_reset_q;
    assign x_ball_vel = vel_q;
    assign y_ball_vel = vel_q;
    assign serve_dir  = serve_dir_q;
    assign score_a    = score_a_q;
    assign score_b    = score_b_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
